// File: rtl/brick_memory.sv
// Brick-state store for the collision stage: combinational probe lookup, health
// write-back, bricks-remaining count and a draw-request port to the VGA drawer.
module brick_memory #(
    parameter int BRICKX      = 40,
    parameter int BRICKY      = 20,
    parameter int COLS        = 8,
    parameter int ROWS        = 6,
    parameter int BRICK_ROWS  = 4,
    parameter int INIT_HEALTH = 3,
    parameter int CNT_W       = 6
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [9:0]       memx,
    input  logic [9:0]       memy,
    output logic [9:0]       brickx,
    output logic [9:0]       bricky,
    output logic [1:0]       health,
    input  logic             game_write,
    input  logic [1:0]       game_health,
    output logic             busy,
    output logic             draw_valid,
    input  logic             draw_ready,
    output logic [9:0]       draw_x,
    output logic [9:0]       draw_y,
    output logic [2:0]       draw_colour,
    output logic [CNT_W-1:0] bricks_left,
    output logic             level_clear,
    output logic             draw_overflow,
    output logic [1:0]       dbg_state
);

    localparam int CELLS = ROWS * COLS;
    localparam int IDX_W = $clog2(CELLS);
    localparam int LAST  = BRICK_ROWS * COLS - 1;

    // Draw handshake: a request transfers on a clock edge where draw_valid and
    // draw_ready are both 1; once raised, draw_valid and the payload hold until then.
    typedef enum logic [1:0] {
        S_INIT_WR   = 2'd0,
        S_INIT_DRAW = 2'd1,
        S_RUN       = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [IDX_W-1:0]   r_idx;
    logic [1:0]         r_cells [0:CELLS-1];
    logic [CNT_W-1:0]   r_bricks_left;
    logic               r_draw_overflow;
    logic [22:0]        r_fifo [0:1];
    logic               r_rd_ptr;
    logic               r_wr_ptr;
    logic [1:0]         r_fifo_cnt;

    logic [9:0]         w_col;
    logic [9:0]         w_row;
    logic               w_in_grid;
    logic [IDX_W-1:0]   w_cell_idx;
    logic [1:0]         w_cell_h;
    logic               w_wr_hit;
    logic               w_pop;
    logic               w_push_ok;
    logic [9:0]         w_init_x;
    logic [9:0]         w_init_y;
    logic [22:0]        w_head;

    function automatic logic [2:0] colour_of(input logic [1:0] h);
        case (h)
            2'd0:    colour_of = 3'b000;
            2'd1:    colour_of = 3'b110;
            2'd2:    colour_of = 3'b011;
            default: colour_of = 3'b101;
        endcase
    endfunction

    assign w_col      = memx / 10'(BRICKX);
    assign w_row      = memy / 10'(BRICKY);
    assign w_in_grid  = (w_col < 10'(COLS)) && (w_row < 10'(ROWS));
    assign w_cell_idx = IDX_W'(w_row) * IDX_W'(COLS) + IDX_W'(w_col);
    assign w_cell_h   = w_in_grid ? r_cells[w_cell_idx] : 2'd0;

    assign brickx = w_col * 10'(BRICKX);
    assign bricky = w_row * 10'(BRICKY);
    assign busy   = (r_state != S_RUN);
    assign health = busy ? 2'd0 : w_cell_h;

    // Writes to empty cells are dropped so the count can never underflow.
    assign w_wr_hit  = (r_state == S_RUN) && game_write && (w_cell_h != 2'd0);
    assign w_pop     = (r_state == S_RUN) && (r_fifo_cnt != 2'd0) && draw_ready;
    assign w_push_ok = w_wr_hit && ((r_fifo_cnt != 2'd2) || w_pop);

    assign w_init_x = 10'(r_idx % IDX_W'(COLS)) * 10'(BRICKX);
    assign w_init_y = 10'(r_idx / IDX_W'(COLS)) * 10'(BRICKY);
    assign w_head   = r_fifo[r_rd_ptr];

    assign draw_valid    = (r_state == S_INIT_DRAW) || ((r_state == S_RUN) && (r_fifo_cnt != 2'd0));
    assign draw_x        = (r_state == S_RUN) ? w_head[22:13] : w_init_x;
    assign draw_y        = (r_state == S_RUN) ? w_head[12:3]  : w_init_y;
    assign draw_colour   = (r_state == S_RUN) ? w_head[2:0]   : colour_of(2'(INIT_HEALTH));
    assign bricks_left   = r_bricks_left;
    assign level_clear   = (r_bricks_left == '0) && !busy;
    assign draw_overflow = r_draw_overflow;
    assign dbg_state     = r_state;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_INIT_WR:   w_next_state = S_INIT_DRAW;
            S_INIT_DRAW: if (draw_ready) w_next_state = (r_idx == IDX_W'(LAST)) ? S_RUN : S_INIT_WR;
            S_RUN:       w_next_state = S_RUN;
            default:     w_next_state = S_INIT_WR;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_INIT_WR;
            r_idx   <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_INIT_DRAW && draw_ready && r_idx != IDX_W'(LAST))
                r_idx <= r_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < CELLS; i++) r_cells[i] <= 2'd0;
            r_bricks_left <= '0;
        end else if (r_state == S_INIT_WR) begin
            r_cells[r_idx] <= 2'(INIT_HEALTH);
            r_bricks_left  <= r_bricks_left + CNT_W'(1);
        end else if (w_wr_hit) begin
            r_cells[w_cell_idx] <= game_health;
            if (game_health == 2'd0) r_bricks_left <= r_bricks_left - CNT_W'(1);
        end
    end

    // Two-entry repaint queue; a push into a full queue succeeds if the head leaves this cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_fifo[0]       <= '0;
            r_fifo[1]       <= '0;
            r_rd_ptr        <= 1'b0;
            r_wr_ptr        <= 1'b0;
            r_fifo_cnt      <= 2'd0;
            r_draw_overflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_fifo[r_wr_ptr] <= {brickx, bricky, colour_of(game_health)};
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) r_rd_ptr <= ~r_rd_ptr;
            if (w_push_ok && !w_pop)      r_fifo_cnt <= r_fifo_cnt + 2'd1;
            else if (!w_push_ok && w_pop) r_fifo_cnt <= r_fifo_cnt - 2'd1;
            if (w_wr_hit && !w_push_ok) r_draw_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_brick_memory.sv
// Directed bench for brick_memory: init sweep, lookup, write-back, draw queue and reset.
module tb_brick_memory;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [9:0] memx = '0;
    logic [9:0] memy = '0;
    logic [9:0] brickx;
    logic [9:0] bricky;
    logic [1:0] health;
    logic       game_write = 1'b0;
    logic [1:0] game_health = '0;
    logic       busy;
    logic       draw_valid;
    logic       draw_ready = 1'b1;
    logic [9:0] draw_x;
    logic [9:0] draw_y;
    logic [2:0] draw_colour;
    logic [5:0] bricks_left;
    logic       level_clear;
    logic       draw_overflow;
    logic [1:0] dbg_state;

    int checks = 0;
    int failures = 0;

    brick_memory dut (
        .clk(clk), .resetn(resetn), .memx(memx), .memy(memy),
        .brickx(brickx), .bricky(bricky), .health(health),
        .game_write(game_write), .game_health(game_health), .busy(busy),
        .draw_valid(draw_valid), .draw_ready(draw_ready), .draw_x(draw_x),
        .draw_y(draw_y), .draw_colour(draw_colour), .bricks_left(bricks_left),
        .level_clear(level_clear), .draw_overflow(draw_overflow), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic do_write(input logic [9:0] x, input logic [9:0] y, input logic [1:0] h);
        @(negedge clk);
        memx = x; memy = y; game_health = h; game_write = 1'b1;
        @(posedge clk); #1;
        game_write = 1'b0;
    endtask

    task automatic check_draw(input string name, input logic v, input logic [9:0] x,
                              input logic [9:0] y, input logic [2:0] c);
        checks++;
        if (draw_valid !== v || (v && (draw_x !== x || draw_y !== y || draw_colour !== c))) begin
            failures++;
            $display("FAIL %s: got v=%0b (%0d,%0d,%b) want v=%0b (%0d,%0d,%b)",
                     name, draw_valid, draw_x, draw_y, draw_colour, v, x, y, c);
        end
    endtask

    task automatic check_probe(input string name, input logic [9:0] x, input logic [9:0] y,
                               input logic [1:0] h);
        memx = x; memy = y; #1;
        checks++;
        if (health !== h) begin
            failures++;
            $display("FAIL %s: health got %0d want %0d", name, health, h);
        end
    endtask

    task automatic check_count(input string name, input logic [5:0] n);
        checks++;
        if (bricks_left !== n) begin
            failures++;
            $display("FAIL %s: bricks_left got %0d want %0d", name, bricks_left, n);
        end
    endtask

    task automatic test_reset;
        resetn = 1'b0; draw_ready = 1'b1; #1;
        checks++;
        if (busy !== 1'b1 || draw_valid !== 1'b0 || bricks_left !== 6'd0 || level_clear !== 1'b0
            || draw_overflow !== 1'b0 || dbg_state !== 2'd0 || health !== 2'd0) begin
            failures++;
            $display("FAIL reset: busy=%0b valid=%0b left=%0d clear=%0b ovf=%0b st=%0d h=%0d want 1 0 0 0 0 0 0",
                     busy, draw_valid, bricks_left, level_clear, draw_overflow, dbg_state, health);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_init;
        int hs = 0;
        int cyc = 0;
        while (cyc < 200) begin
            if (draw_valid && draw_ready) begin
                check_draw("init_draw", 1'b1, 10'((hs % 8) * 40), 10'((hs / 8) * 20), 3'b101);
                hs++;
            end
            @(posedge clk); #1;
            cyc++;
            if (!busy) break;
        end
        checks++;
        if (hs !== 32 || cyc !== 64) begin
            failures++;
            $display("FAIL init_len: handshakes=%0d cycles=%0d want 32 64", hs, cyc);
        end
        check_count("init_count", 6'd32);
    endtask

    task automatic test_lookup;
        check_probe("lookup_live", 10'd85, 10'd25, 2'd3);
        checks++;
        if (brickx !== 10'd80 || bricky !== 10'd20) begin
            failures++;
            $display("FAIL lookup_snap: got (%0d,%0d) want (80,20)", brickx, bricky);
        end
        check_probe("lookup_empty_row", 10'd85, 10'd100, 2'd0);
        check_probe("lookup_off_grid", 10'd330, 10'd25, 2'd0);
        checks++;
        if (brickx !== 10'd320) begin
            failures++;
            $display("FAIL lookup_off_snap: brickx got %0d want 320", brickx);
        end
    endtask

    task automatic test_write;
        @(negedge clk);
        memx = 10'd80; memy = 10'd20; game_health = 2'd2; game_write = 1'b1; #1;
        checks++;
        if (health !== 2'd3) begin
            failures++;
            $display("FAIL write_old_value: health got %0d want 3", health);
        end
        @(posedge clk); #1;
        game_write = 1'b0;
        check_draw("write_draw", 1'b1, 10'd80, 10'd20, 3'b011);
        check_probe("write_health", 10'd80, 10'd20, 2'd2);
        check_count("write_count", 6'd32);
        do_write(10'd80, 10'd20, 2'd0);
        check_draw("erase_draw", 1'b1, 10'd80, 10'd20, 3'b000);
        check_count("erase_count", 6'd31);
        @(posedge clk); #1;
        check_draw("write_drained", 1'b0, 10'd0, 10'd0, 3'b000);
    endtask

    task automatic test_full_pop;
        draw_ready = 1'b0;
        do_write(10'd0, 10'd40, 2'd1);
        do_write(10'd40, 10'd40, 2'd2);
        draw_ready = 1'b1;
        do_write(10'd80, 10'd40, 2'd1);
        checks++;
        if (draw_overflow !== 1'b0) begin
            failures++;
            $display("FAIL full_pop_overflow: got %0b want 0", draw_overflow);
        end
        check_draw("full_pop_head1", 1'b1, 10'd40, 10'd40, 3'b011);
        @(posedge clk); #1;
        check_draw("full_pop_head2", 1'b1, 10'd80, 10'd40, 3'b110);
        @(posedge clk); #1;
        check_draw("full_pop_empty", 1'b0, 10'd0, 10'd0, 3'b000);
    endtask

    task automatic test_overflow;
        draw_ready = 1'b0;
        do_write(10'd0, 10'd0, 2'd1);
        do_write(10'd40, 10'd0, 2'd2);
        checks++;
        if (draw_overflow !== 1'b0) begin
            failures++;
            $display("FAIL ovf_early: got %0b want 0", draw_overflow);
        end
        do_write(10'd80, 10'd0, 2'd1);
        checks++;
        if (draw_overflow !== 1'b1) begin
            failures++;
            $display("FAIL ovf_set: got %0b want 1", draw_overflow);
        end
        check_probe("ovf_cell_a", 10'd0, 10'd0, 2'd1);
        check_probe("ovf_cell_b", 10'd40, 10'd0, 2'd2);
        check_probe("ovf_cell_c", 10'd80, 10'd0, 2'd1);
        check_count("ovf_count", 6'd31);
        draw_ready = 1'b1;
        check_draw("ovf_drain1", 1'b1, 10'd0, 10'd0, 3'b110);
        @(posedge clk); #1;
        check_draw("ovf_drain2", 1'b1, 10'd40, 10'd0, 3'b011);
        @(posedge clk); #1;
        check_draw("ovf_drain_end", 1'b0, 10'd0, 10'd0, 3'b000);
    endtask

    task automatic test_clear;
        draw_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (i == 31) begin
                check_count("clear_before_last", 6'd1);
                checks++;
                if (level_clear !== 1'b0) begin
                    failures++;
                    $display("FAIL clear_early: level_clear got %0b want 0", level_clear);
                end
            end
            do_write(10'((i % 8) * 40 + 5), 10'((i / 8) * 20 + 3), 2'd0);
        end
        check_count("clear_count", 6'd0);
        checks++;
        if (level_clear !== 1'b1) begin
            failures++;
            $display("FAIL level_clear: got %0b want 1", level_clear);
        end
        repeat (3) @(posedge clk);
        #1;
        do_write(10'd5, 10'd3, 2'd3);
        check_draw("dead_write_no_draw", 1'b0, 10'd0, 10'd0, 3'b000);
        check_count("dead_write_count", 6'd0);
        check_probe("dead_write_health", 10'd5, 10'd3, 2'd0);
    endtask

    task automatic test_reset_mid_init;
        draw_ready = 1'b1;
        @(negedge clk); resetn = 1'b0;
        @(negedge clk); resetn = 1'b1;
        repeat (21) @(posedge clk);
        #1;
        checks++;
        if (dbg_state !== 2'd1 || draw_x !== 10'd80 || draw_y !== 10'd20 || bricks_left !== 6'd11) begin
            failures++;
            $display("FAIL mid_init_pos: st=%0d x=%0d y=%0d left=%0d want 1 80 20 11",
                     dbg_state, draw_x, draw_y, bricks_left);
        end
        resetn = 1'b0; #1;
        checks++;
        if (draw_valid !== 1'b0 || busy !== 1'b1 || bricks_left !== 6'd0 || dbg_state !== 2'd0) begin
            failures++;
            $display("FAIL mid_init_reset: valid=%0b busy=%0b left=%0d st=%0d want 0 1 0 0",
                     draw_valid, busy, bricks_left, dbg_state);
        end
        @(negedge clk); resetn = 1'b1; draw_ready = 1'b0;
        @(posedge clk); #1;
        check_draw("restart_first", 1'b1, 10'd0, 10'd0, 3'b101);
        @(posedge clk); #1;
        check_draw("restart_hold", 1'b1, 10'd0, 10'd0, 3'b101);
        check_count("restart_count", 6'd1);
        draw_ready = 1'b1;
        for (int c = 0; c < 100 && busy; c++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL restart_timeout: busy got %0b want 0", busy);
        end
        check_count("restart_done_count", 6'd32);
    endtask

    task automatic test_reset_mid_drain;
        draw_ready = 1'b0;
        do_write(10'd0, 10'd60, 2'd1);
        do_write(10'd40, 10'd60, 2'd1);
        do_write(10'd80, 10'd60, 2'd1);
        draw_ready = 1'b1;
        @(posedge clk); #1;
        check_draw("drain_head", 1'b1, 10'd40, 10'd60, 3'b110);
        resetn = 1'b0; #1;
        checks++;
        if (draw_valid !== 1'b0 || draw_overflow !== 1'b0 || bricks_left !== 6'd0
            || busy !== 1'b1 || level_clear !== 1'b0) begin
            failures++;
            $display("FAIL drain_reset: valid=%0b ovf=%0b left=%0d busy=%0b clear=%0b want 0 0 0 1 0",
                     draw_valid, draw_overflow, bricks_left, busy, level_clear);
        end
        @(negedge clk); resetn = 1'b1;
        @(posedge clk); #1;
        check_draw("drain_restart", 1'b1, 10'd0, 10'd0, 3'b101);
    endtask

    initial begin
        test_reset;
        test_init;
        test_lookup;
        test_write;
        test_full_pop;
        test_overflow;
        test_clear;
        test_reset_mid_init;
        test_reset_mid_drain;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
